kronos_dmem: RTL
================

KRONOS_DMEM -- requirements
Module: kronos_dmem

Interface
REQ-001 Parameter DEPTH, default 1024, memory size in 32-bit words; SHALL be a power of two, 4 to 65536.
REQ-002 Parameter WAIT_STATES, default 0, extra cycles inserted before each grant; SHALL be 0 to 15.
REQ-003 clk  input  1  single clock for all state; all state SHALL update on rising edge.
REQ-004 rstz  input  1  reset, asynchronous, active-high (asserted = 1).
REQ-005 data_addr  input  32  byte address from the initiator; bits [1:0] ignored.
REQ-006 data_rd_req  input  1  read request, held by the initiator until the grant cycle.
REQ-007 data_wr_req  input  1  write request, held by the initiator until the grant cycle.
REQ-008 data_wr_data  input  32  write data.
REQ-009 data_wr_mask  input  4  byte enables; bit i enables data_wr_data[8i+7:8i].
REQ-010 data_rd_data  output  32  read data, valid in the read grant cycle.
REQ-011 data_gnt  output  1  one-cycle completion pulse for the accepted request.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The block SHALL implement states IDLE, WAIT and GRANT.
REQ-014 IDLE: if data_rd_req or data_wr_req is 1 at a rising edge, the block SHALL accept the request and latch the following:
  - word index = data_addr[log2(DEPTH)+1:2]
  - data_wr_data, data_wr_mask
  - request type
REQ-015 Accept transition: the next state SHALL be GRANT if WAIT_STATES==0, else WAIT with the wait counter loaded to WAIT_STATES-1.
REQ-016 WAIT: the counter SHALL decrement each cycle; the state SHALL move to GRANT on the edge where the counter is 0.
REQ-017 Latency: a request first sampled in IDLE at edge N SHALL see data_gnt=1 during cycle N+1+WAIT_STATES.
REQ-018 Grant pulse: data_gnt SHALL be 1 only in GRANT and exactly one cycle per accepted request; GRANT SHALL always return to IDLE.
REQ-019 Request inputs in GRANT SHALL be ignored; the earliest next acceptance is the edge ending the first IDLE cycle after GRANT.
REQ-020 Address width: address bits above log2(DEPTH)+1 SHALL be ignored, so addresses wrap modulo DEPTH words; no error is raised.
REQ-021 Read data: for a read, data_rd_data SHALL present the addressed word during GRANT.
REQ-022 Read data hold: data_rd_data SHALL hold its value until the next read grant; writes SHALL NOT change data_rd_data.
REQ-023 Write commit: a write SHALL update memory at the edge ending the GRANT cycle, writing only the bytes enabled in the latched mask.
REQ-024 Zero mask: a write with mask 4'b0000 SHALL still grant and SHALL leave memory unchanged.
REQ-025 Simultaneous requests: data_rd_req and data_wr_req both 1 at acceptance SHALL be treated as a write; the read SHALL be dropped and data_rd_data SHALL NOT update.
REQ-026 Abort: if both request inputs are 0 at any edge while in WAIT, the block SHALL return to IDLE with no grant and no memory write.
REQ-027 Ordering: a read accepted after a write's GRANT SHALL return the newly written bytes.
REQ-028 The memory array SHALL be inferable as a single-port synchronous RAM, with one access per cycle at most.

Reset
REQ-029 While rstz=1 the block SHALL force state IDLE, wait counter 0, data_gnt=0, busy=0 and data_rd_data=0.
REQ-030 Reset asserted in WAIT or GRANT SHALL abandon the request; a pending write SHALL NOT commit.
REQ-031 Memory contents SHALL NOT be cleared by reset.
REQ-032 The first request SHALL be accepted at the first rising edge after rstz deasserts.

Verification
REQ-033 WAIT_STATES=0: write 0xDEADBEEF mask 4'hF to addr 0x10, then read 0x10 -> each gnt 1 cycle after acceptance; read data 0xDEADBEEF.
REQ-034 WAIT_STATES=3: read request held -> gnt exactly 4 cycles after acceptance; busy=1 for those 4 cycles, data_gnt=1 for 1 cycle.
REQ-035 Word 0x20 holds 0x11223344; write 0xAABBCCDD mask 4'b0101 -> read returns 0x11BB33DD; mask 4'b0000 write leaves the word unchanged and still grants.
REQ-036 DEPTH=1024: write 0x5A5A5A5A to addr 0x1000 -> read of addr 0x0 returns 0x5A5A5A5A (wrap-around).
REQ-037 Both requests asserted with data 0x12345678 -> write occurs and data_rd_data keeps its prior value.
REQ-038 Request aborts and resets:
  - WAIT_STATES=5, write dropped mid-WAIT -> no gnt, memory unchanged.
  - Reset during GRANT of a write -> no commit, data_gnt=0, data_rd_data=0.

Source files
------------

// File: rtl/kronos_dmem.sv
// kronos_dmem: single-port word-addressed data memory with byte-enabled
// writes, a configurable number of wait states before each grant, and a
// one-cycle grant pulse per accepted request.
module kronos_dmem #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [31:0] data_addr,
    input  logic        data_rd_req,
    input  logic        data_wr_req,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_wr_mask,
    output logic [31:0] data_rd_data,
    output logic        data_gnt,
    output logic        busy
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    wait_cnt;
    logic [3:0]    wait_cnt_nxt;

    // Request context captured at acceptance
    logic [AW-1:0] word_idx;
    logic [31:0]   wr_data_lat;
    logic [3:0]    wr_mask_lat;
    logic          is_write;

    logic          accept;
    logic          rd_load;
    logic          wr_commit;
    logic [AW-1:0] ram_idx;

    logic [31:0]   mem [DEPTH];

    // Byte-offset bits and bits above the array size are deliberately dropped,
    // which makes out-of-range addresses wrap modulo DEPTH.
    logic          unused_addr;
    assign unused_addr = ^{data_addr[31:AW+2], data_addr[1:0]};

    assign busy = (state != IDLE);

    // Next-state, wait counter and memory access strobes.
    // The read is performed on the edge entering GRANT and the write on the
    // edge leaving GRANT, so the array never sees two accesses in one cycle.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        data_gnt     = 1'b0;
        accept       = 1'b0;
        rd_load      = 1'b0;
        wr_commit    = 1'b0;
        ram_idx      = word_idx;
        unique case (state)
            IDLE: begin
                // Straight-through address so a zero-wait read can load on the accept edge
                ram_idx = data_addr[AW+1:2];
                if (data_rd_req || data_wr_req) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_nxt = GRANT;
                        rd_load   = !data_wr_req;
                    end else begin
                        state_nxt    = WAIT;
                        wait_cnt_nxt = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!data_rd_req && !data_wr_req) begin
                    // Initiator withdrew the request: drop it without granting
                    state_nxt    = IDLE;
                    wait_cnt_nxt = 4'd0;
                end else if (wait_cnt == 4'd0) begin
                    state_nxt = GRANT;
                    rd_load   = !is_write;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            GRANT: begin
                data_gnt  = 1'b1;
                wr_commit = is_write;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt    = IDLE;
                wait_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Control state register; reset abandons any request in flight.
    always_ff @(posedge clk or posedge rstz) begin
        if (rstz) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Capture the request context; a simultaneous read+write is taken as a write.
    always_ff @(posedge clk) begin
        if (accept) begin
            word_idx    <= data_addr[AW+1:2];
            wr_data_lat <= data_wr_data;
            wr_mask_lat <= data_wr_mask;
            is_write    <= data_wr_req;
        end
    end

    // Read data register: updated only by a read grant, cleared by reset.
    always_ff @(posedge clk or posedge rstz) begin
        if (rstz) begin
            data_rd_data <= 32'd0;
        end else if (rd_load) begin
            data_rd_data <= mem[ram_idx];
        end
    end

    // Byte-enabled write into the array at the end of a write grant.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask_lat[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_data_lat[8*i +: 8];
                end
            end
        end
    end

endmodule
